sdrc_xfr_req_gen: RTL
=====================

# sdrc_xfr_req_gen

Application-side request initiator for the SDRAM controller's app request port. It accepts one long transfer command (address, length in APP_DW words, direction) and splits it into a sequence of controller requests. Each request is at most MAX_BURST words and never crosses a 2^BND_AW-word boundary. A request is issued only when the external write-data FIFO holds, or the read-data FIFO can absorb, every beat already committed, because the controller cannot stall data beats. It sits between a DMA/client FIFO pair and the controller's app_req/app_wr/app_rd interface.

## Interface
- APP_AW, 30, app word-address width
- APP_DW, 32, app data width
- APP_BW, 4, app byte-enable width
- APP_RW, 9, app_req_len width
- MAX_BURST, 256, max words per request (1..2^APP_RW-1)
- BND_AW, 10, requests must not cross a 2^BND_AW-word boundary
- XFR_LW, 16, transfer length / FIFO level width

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- xfr_start  in  1  command strobe (sampled in IDLE only)
- xfr_addr  in  APP_AW  start word address
- xfr_len  in  XFR_LW  length in words
- xfr_wr_n  in  1  0 = write, 1 = read
- xfr_busy  out  1  command in progress
- xfr_done  out  1  one-cycle completion pulse
- wf_data  in  APP_DW  write FIFO head (show-ahead)
- wf_count  in  XFR_LW  words available in write FIFO
- wf_pop  out  1  write FIFO pop
- rf_space  in  XFR_LW  free words in read FIFO
- rf_push  out  1  read FIFO push
- rf_data  out  APP_DW  read FIFO data
- app_req  out  1  request to controller
- app_req_addr  out  APP_AW  request word address
- app_req_len  out  APP_RW  request length in words
- app_req_wr_n  out  1  request direction
- app_req_dma_last  out  1  final chunk of the transfer
- app_req_ack  in  1  request accepted
- app_wr_data  out  APP_DW  = wf_data
- app_wr_en_n  out  APP_BW  all zeros
- app_wr_next  in  1  controller consumed a write beat
- app_rd_data  in  APP_DW  read beat data
- app_rd_valid  in  1  read beat valid

## Operation
- Registers:
  - cur_addr (APP_AW)
  - remain (XFR_LW)
  - chunk (APP_RW)
  - dir (latched xfr_wr_n)
  - pending (XFR_LW+1): beats acknowledged but not yet transferred
- State IDLE:
  - On xfr_start: latch addr/len/dir and set busy.
  - len==0 → DRAIN; otherwise → CALC.
- State CALC: chunk <= min(remain, MAX_BURST, 2^BND_AW − cur_addr[BND_AW-1:0]) → WAIT.
- State WAIT:
  - Budget for writes: wf_count ≥ pending + chunk.
  - Budget for reads: rf_space ≥ pending + chunk.
  - Compare at XFR_LW+1 bits.
  - When budget ok → REQ.
- State REQ:
  - app_req=1, with addr=cur_addr, len=chunk, wr_n=dir, dma_last=(chunk==remain).
  - All request fields are held stable until app_req_ack.
  - On ack: cur_addr += chunk (wraps mod 2^APP_AW), remain −= chunk, pending += chunk.
  - Then → DRAIN if remain becomes 0, else → CALC.
- State DRAIN: xfr_done=1 in the cycle pending==0, then → IDLE, busy cleared.
- Beat accounting:
  - wf_pop = app_wr_next & busy & ~dir.
  - rf_push = app_rd_valid & busy & dir.
  - rf_data = app_rd_data.
  - Each counted beat decrements pending.
  - Ack and beat in the same cycle: pending += chunk − 1.
  - A beat with pending==0 is ignored; pending saturates at 0.
- xfr_start while busy is ignored.
- Budget only grows while waiting: pops and pushes reduce pending by the same amount as FIFO level/space changes. An asserted app_req is therefore never withdrawn.

## Timing
- Reset values: app_req 0, app_req_addr 0, app_req_len 0, app_req_wr_n 1, app_req_dma_last 0, xfr_busy 0, xfr_done 0, state IDLE, pending 0.
- Reset mid-operation aborts the transfer; no done pulse is issued.
- xfr_start at T → CALC at T+1, WAIT at T+2, app_req first high at T+3 if budget ok at T+2.
- Ack at N → app_req low at N+1, next app_req earliest at N+3.
- xfr_done coincides with the cycle the last beat has been counted (pending==0 seen in DRAIN); xfr_busy falls the following cycle.
- The next xfr_start is accepted the cycle after xfr_done.

## Test plan
- Write, addr 0x000, len 600, wf_count 1023, ack 2 cycles after each req:
  - Required requests: (0x000,256,last0), (0x100,256,last0), (0x200,88,last1).
  - 600 wf_pop pulses, then one xfr_done.
- Read, addr 0x3F0, len 40, rf_space 512:
  - Required requests: (0x3F0,16,0), (0x400,24,1).
  - 40 rf_push pulses with rf_data == app_rd_data.
- Write, len 64, wf_count 63:
  - app_req stays low indefinitely.
  - Raise wf_count to 64 at cycle K → app_req high at K+1.
- Address wrap: addr 0x3FFFFFF8, len 16 → requests (0x3FFFFFF8,8,0), (0x00000000,8,1).
- len 0 at T → no app_req; xfr_done high at T+1; busy low at T+2.
- Reset asserted while app_req high, plus xfr_start while busy:
  - Reset → all outputs at reset values next cycle.
  - Ignored start leaves the address sequence unchanged.

Source files
------------

// File: rtl/sdrc_xfr_req_gen.sv
// sdrc_xfr_req_gen
// Splits one long application transfer into controller requests of at most
// MAX_BURST words. A request never crosses a 2^BND_AW-word boundary. It is
// issued only once the data FIFO on the application side can cover every beat
// already committed plus the new chunk, because the controller never stalls
// data beats.
module sdrc_xfr_req_gen #(
  parameter int APP_AW    = 30,
  parameter int APP_DW    = 32,
  parameter int APP_BW    = 4,
  parameter int APP_RW    = 9,
  parameter int MAX_BURST = 256,
  parameter int BND_AW    = 10,
  parameter int XFR_LW    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              xfr_start,
  input  logic [APP_AW-1:0] xfr_addr,
  input  logic [XFR_LW-1:0] xfr_len,
  input  logic              xfr_wr_n,
  output logic              xfr_busy,
  output logic              xfr_done,
  input  logic [APP_DW-1:0] wf_data,
  input  logic [XFR_LW-1:0] wf_count,
  output logic              wf_pop,
  input  logic [XFR_LW-1:0] rf_space,
  output logic              rf_push,
  output logic [APP_DW-1:0] rf_data,
  output logic              app_req,
  output logic [APP_AW-1:0] app_req_addr,
  output logic [APP_RW-1:0] app_req_len,
  output logic              app_req_wr_n,
  output logic              app_req_dma_last,
  input  logic              app_req_ack,
  output logic [APP_DW-1:0] app_wr_data,
  output logic [APP_BW-1:0] app_wr_en_n,
  input  logic              app_wr_next,
  input  logic [APP_DW-1:0] app_rd_data,
  input  logic              app_rd_valid
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_WAIT  = 3'd2,
    S_REQ   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [APP_AW-1:0]   cur_addr_r;
  logic [XFR_LW-1:0]   remain_r;
  logic [APP_RW-1:0]   chunk_r;
  logic                dir_r;
  logic [XFR_LW:0]     pending_r;
  logic                busy_r;
  logic                req_r;
  logic [APP_AW-1:0]   req_addr_r;
  logic [APP_RW-1:0]   req_len_r;
  logic                req_wr_n_r;
  logic                req_last_r;

  logic                accept_s;
  logic                beat_s;
  logic [XFR_LW-1:0]   level_s;
  logic [XFR_LW:0]     need_s;
  logic                budget_ok_s;
  logic [XFR_LW-1:0]   remain_after_s;
  logic [31:0]         bnd_room_s;
  logic [31:0]         chunk_calc_s;
  logic [XFR_LW:0]     pending_sum_s;
  logic [XFR_LW:0]     pending_nxt_s;
  logic                pending_zero_s;

  // Data path passthroughs and beat qualification.
  assign wf_pop      = app_wr_next & busy_r & ~dir_r;
  assign rf_push     = app_rd_valid & busy_r & dir_r;
  assign rf_data     = app_rd_data;
  assign app_wr_data = wf_data;
  assign app_wr_en_n = {APP_BW{1'b0}};

  assign xfr_busy         = busy_r;
  assign app_req          = req_r;
  assign app_req_addr     = req_addr_r;
  assign app_req_len      = req_len_r;
  assign app_req_wr_n     = req_wr_n_r;
  assign app_req_dma_last = req_last_r;

  assign pending_zero_s = (pending_r == {(XFR_LW+1){1'b0}});
  // Done is decoded from registers only, so it is glitch-free.
  assign xfr_done       = (state_r == S_DRAIN) && pending_zero_s;

  assign accept_s       = (state_r == S_REQ) && app_req_ack;
  assign beat_s         = wf_pop | rf_push;
  assign remain_after_s = remain_r - XFR_LW'(chunk_r);

  // Budget check: the FIFO must cover committed beats plus the new chunk.
  always_comb begin
    level_s     = dir_r ? rf_space : wf_count;
    need_s      = pending_r + (XFR_LW+1)'(chunk_r);
    budget_ok_s = ({1'b0, level_s} >= need_s);
  end

  // Chunk size: smallest of words left, burst cap and room to the boundary.
  always_comb begin
    bnd_room_s   = (32'd1 << BND_AW) - 32'(cur_addr_r[BND_AW-1:0]);
    chunk_calc_s = 32'(remain_r);
    if (32'(MAX_BURST) < chunk_calc_s) begin
      chunk_calc_s = 32'(MAX_BURST);
    end else begin
      chunk_calc_s = chunk_calc_s;
    end
    if (bnd_room_s < chunk_calc_s) begin
      chunk_calc_s = bnd_room_s;
    end else begin
      chunk_calc_s = chunk_calc_s;
    end
  end

  // Committed-beat counter: add on acknowledge, drop one per counted beat, floor at zero.
  always_comb begin
    pending_sum_s = pending_r + (accept_s ? (XFR_LW+1)'(chunk_r) : {(XFR_LW+1){1'b0}});
    pending_nxt_s = pending_sum_s;
    if (beat_s && (pending_sum_s != {(XFR_LW+1){1'b0}})) begin
      pending_nxt_s = pending_sum_s - {{XFR_LW{1'b0}}, 1'b1};
    end else begin
      pending_nxt_s = pending_sum_s;
    end
  end

  // Next-state decode for the request sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (xfr_start) begin
          state_nxt_s = (xfr_len == {XFR_LW{1'b0}}) ? S_DRAIN : S_CALC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CALC: state_nxt_s = S_WAIT;
      S_WAIT: begin
        if (budget_ok_s) begin
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_REQ: begin
        if (accept_s) begin
          state_nxt_s = (remain_after_s == {XFR_LW{1'b0}}) ? S_DRAIN : S_CALC;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_DRAIN: begin
        if (pending_zero_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Transfer bookkeeping and registered request outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_addr_r <= {APP_AW{1'b0}};
      remain_r   <= {XFR_LW{1'b0}};
      chunk_r    <= {APP_RW{1'b0}};
      dir_r      <= 1'b1;
      pending_r  <= {(XFR_LW+1){1'b0}};
      busy_r     <= 1'b0;
      req_r      <= 1'b0;
      req_addr_r <= {APP_AW{1'b0}};
      req_len_r  <= {APP_RW{1'b0}};
      req_wr_n_r <= 1'b1;
      req_last_r <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      case (state_r)
        S_IDLE: begin
          if (xfr_start) begin
            cur_addr_r <= xfr_addr;
            remain_r   <= xfr_len;
            dir_r      <= xfr_wr_n;
            busy_r     <= 1'b1;
          end
        end
        S_CALC: begin
          chunk_r <= chunk_calc_s[APP_RW-1:0];
        end
        S_WAIT: begin
          if (budget_ok_s) begin
            req_r      <= 1'b1;
            req_addr_r <= cur_addr_r;
            req_len_r  <= chunk_r;
            req_wr_n_r <= dir_r;
            req_last_r <= (32'(chunk_r) == 32'(remain_r));
          end
        end
        S_REQ: begin
          if (accept_s) begin
            req_r      <= 1'b0;
            cur_addr_r <= cur_addr_r + APP_AW'(chunk_r);
            remain_r   <= remain_after_s;
          end
        end
        S_DRAIN: begin
          if (pending_zero_s) begin
            busy_r <= 1'b0;
          end
        end
        default: begin
          busy_r <= 1'b0;
          req_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
